// File: rtl/rgmii_rx_pkg.sv
// Shared types and constants for the RGMII receive frame sequencer.
package rgmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         LEN_W         = 16;
    localparam int         PRE_CNT_W     = 8;

endpackage

// File: rtl/rgmii_rx_nibble_pack.sv
// Builds bytes from the DDR-captured RXD halves: one byte per cycle at 1G,
// two nibbles (low first) per byte at 10/100.
module rgmii_rx_nibble_pack
    import rgmii_rx_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       dv_i,
    input  logic       speed_1g_i,
    input  logic [3:0] rxd_q1_i,
    input  logic [3:0] rxd_q2_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       phase_o
);

    logic       r_phase;
    logic [3:0] r_lo_nib;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_phase  <= 1'b0;
            r_lo_nib <= 4'h0;
        end else if (!dv_i || speed_1g_i) begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_lo_nib <= rxd_q1_i;
            end
        end
    end

    assign byte_o       = speed_1g_i ? {rxd_q2_i, rxd_q1_i} : {rxd_q1_i, r_lo_nib};
    assign byte_valid_o = dv_i && (speed_1g_i || r_phase);
    assign phase_o      = r_phase;

endmodule

// File: rtl/rgmii_rx_frame_ctrl.sv
// RGMII receive sequencer: strips preamble/SFD and emits a framed byte
// stream with last/bad marking and per-frame status pulses.
module rgmii_rx_frame_ctrl
    import rgmii_rx_pkg::*;
#(
    parameter int max_len_p      = 1522,
    parameter int preamble_max_p = 15
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       speed_1g_i,
    input  logic [3:0] rxd_q1_i,
    input  logic [3:0] rxd_q2_i,
    input  logic       rxctl_q1_i,
    input  logic       rxctl_q2_i,
    output logic [7:0] m_tdata_o,
    output logic       m_tvalid_o,
    output logic       m_tlast_o,
    output logic       m_tuser_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic       preamble_err_o
);

    localparam logic [LEN_W-1:0]     MAX_LEN = LEN_W'(max_len_p);
    localparam logic [PRE_CNT_W-1:0] PRE_MAX = PRE_CNT_W'(preamble_max_p);

    rx_state_e            r_state, w_state_next;
    logic                 w_dv, w_er, w_speed_1g, w_byte_valid, w_phase, w_bad;
    logic [7:0]           w_byte;
    logic                 r_speed_1g;
    logic [PRE_CNT_W-1:0] r_pre_cnt, w_pre_cnt_next;
    logic [LEN_W-1:0]     r_len, w_len_next, w_len_inc;
    logic                 r_err, w_err_next, r_oversize, w_oversize_next;
    logic [7:0]           r_hold, w_hold_next;
    logic                 r_hold_full, w_hold_full_next;
    logic [7:0]           r_tdata, w_tdata_next;
    logic                 r_tvalid, w_tvalid_next, r_tlast, w_tlast_next, r_tuser, w_tuser_next;
    logic                 r_frame_ok, w_frame_ok_next, r_frame_err, w_frame_err_next;
    logic                 r_pre_err, w_pre_err_next;

    assign w_dv       = rxctl_q1_i;
    assign w_er       = rxctl_q1_i ^ rxctl_q2_i;
    // Speed follows the pin only while idle; a frame keeps the speed it started with.
    assign w_speed_1g = (r_state == IDLE) ? speed_1g_i : r_speed_1g;
    assign w_len_inc  = (r_len == {LEN_W{1'b1}}) ? r_len : r_len + LEN_W'(1);
    assign w_bad      = r_err | w_er | r_oversize | (!r_speed_1g & w_phase);

    rgmii_rx_nibble_pack u_nibble_pack (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .dv_i         (w_dv),
        .speed_1g_i   (w_speed_1g),
        .rxd_q1_i     (rxd_q1_i),
        .rxd_q2_i     (rxd_q2_i),
        .byte_o       (w_byte),
        .byte_valid_o (w_byte_valid),
        .phase_o      (w_phase)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_next     = r_state;
        w_pre_cnt_next   = r_pre_cnt;
        w_len_next       = r_len;
        w_err_next       = r_err;
        w_oversize_next  = r_oversize;
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
        w_tdata_next     = 8'h00;
        w_tvalid_next    = 1'b0;
        w_tlast_next     = 1'b0;
        w_tuser_next     = 1'b0;
        w_frame_ok_next  = 1'b0;
        w_frame_err_next = 1'b0;
        w_pre_err_next   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_byte_valid) begin
                    if (w_byte == PREAMBLE_BYTE) begin
                        w_state_next   = PREAMBLE;
                        w_pre_cnt_next = PRE_CNT_W'(1);
                    end else begin
                        w_state_next   = DROP;
                        w_pre_err_next = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!w_dv) begin
                    w_state_next = IDLE;
                end else if (w_byte_valid) begin
                    if (w_byte == PREAMBLE_BYTE && r_pre_cnt < PRE_MAX) begin
                        w_pre_cnt_next = r_pre_cnt + PRE_CNT_W'(1);
                    end else if (w_byte == SFD_BYTE) begin
                        w_state_next     = DATA;
                        w_len_next       = '0;
                        w_err_next       = 1'b0;
                        w_oversize_next  = 1'b0;
                        w_hold_full_next = 1'b0;
                    end else begin
                        w_state_next   = DROP;
                        w_pre_err_next = 1'b1;
                    end
                end
            end
            DATA: begin
                // The byte in the hold register is only released once the next
                // byte or the dv drop tells us whether it is the last one.
                if (!w_dv) begin
                    w_state_next     = IDLE;
                    w_hold_full_next = 1'b0;
                    if (r_hold_full) begin
                        w_tvalid_next    = 1'b1;
                        w_tdata_next     = r_hold;
                        w_tlast_next     = 1'b1;
                        w_tuser_next     = w_bad;
                        w_frame_ok_next  = !w_bad;
                        w_frame_err_next = w_bad;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end else begin
                    if (w_er) begin
                        w_err_next = 1'b1;
                    end
                    if (w_byte_valid) begin
                        w_hold_next      = w_byte;
                        w_hold_full_next = 1'b1;
                        w_len_next       = w_len_inc;
                        if (w_len_inc > MAX_LEN) begin
                            w_oversize_next = 1'b1;
                        end
                        if (r_hold_full) begin
                            w_tvalid_next = 1'b1;
                            w_tdata_next  = r_hold;
                        end
                    end
                end
            end
            DROP: begin
                if (!w_dv) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_speed_1g  <= 1'b0;
            r_pre_cnt   <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
            r_oversize  <= 1'b0;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_tdata     <= 8'h00;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_pre_err   <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_speed_1g <= speed_1g_i;
            end
            r_pre_cnt   <= w_pre_cnt_next;
            r_len       <= w_len_next;
            r_err       <= w_err_next;
            r_oversize  <= w_oversize_next;
            r_hold      <= w_hold_next;
            r_hold_full <= w_hold_full_next;
            r_tdata     <= w_tdata_next;
            r_tvalid    <= w_tvalid_next;
            r_tlast     <= w_tlast_next;
            r_tuser     <= w_tuser_next;
            r_frame_ok  <= w_frame_ok_next;
            r_frame_err <= w_frame_err_next;
            r_pre_err   <= w_pre_err_next;
        end
    end

    assign m_tdata_o      = r_tdata;
    assign m_tvalid_o     = r_tvalid;
    assign m_tlast_o      = r_tlast;
    assign m_tuser_o      = r_tuser;
    assign frame_ok_o     = r_frame_ok;
    assign frame_err_o    = r_frame_err;
    assign preamble_err_o = r_pre_err;

endmodule

// File: tb/tb_rgmii_rx_frame_ctrl.sv
// Directed bench for rgmii_rx_frame_ctrl: frames at both speeds, errors,
// preamble limits, length limit and mid-frame reset.
module tb_rgmii_rx_frame_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       speed_1g_i;
    logic [3:0] rxd_q1_i, rxd_q2_i;
    logic       rxctl_q1_i, rxctl_q2_i;
    logic [7:0] m_tdata_o;
    logic       m_tvalid_o, m_tlast_o, m_tuser_o;
    logic       frame_ok_o, frame_err_o, preamble_err_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int fall_cyc = 0;
    int n_ok     = 0;
    int n_err    = 0;
    int n_perr   = 0;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       user;
        logic       st;
        int         cyc;
    } beat_t;
    beat_t beats[$];

    rgmii_rx_frame_ctrl dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .speed_1g_i     (speed_1g_i),
        .rxd_q1_i       (rxd_q1_i),
        .rxd_q2_i       (rxd_q2_i),
        .rxctl_q1_i     (rxctl_q1_i),
        .rxctl_q2_i     (rxctl_q2_i),
        .m_tdata_o      (m_tdata_o),
        .m_tvalid_o     (m_tvalid_o),
        .m_tlast_o      (m_tlast_o),
        .m_tuser_o      (m_tuser_o),
        .frame_ok_o     (frame_ok_o),
        .frame_err_o    (frame_err_o),
        .preamble_err_o (preamble_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt++;

    // Collector: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (m_tvalid_o) begin
            beats.push_back('{m_tdata_o, m_tlast_o, m_tuser_o, frame_ok_o | frame_err_o, cyc_cnt});
        end
        if (frame_ok_o)     n_ok++;
        if (frame_err_o)    n_err++;
        if (preamble_err_o) n_perr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic dv, input logic c2, input logic [3:0] q1, input logic [3:0] q2);
        rxctl_q1_i = dv;
        rxctl_q2_i = c2;
        rxd_q1_i   = q1;
        rxd_q2_i   = q2;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic send_byte(input logic g, input logic [7:0] b, input logic er);
        if (g) begin
            cyc(1'b1, ~er, b[3:0], b[7:4]);
        end else begin
            cyc(1'b1, ~er, b[3:0], 4'h0);
            cyc(1'b1, ~er, b[7:4], 4'h0);
        end
    endtask

    task automatic clear();
        beats.delete();
        n_ok   = 0;
        n_err  = 0;
        n_perr = 0;
    endtask

    // Preamble, SFD, data bytes i mod 256, optional trailing nibble, dv drop.
    // The speed pin is flipped during the data to show it is ignored mid-frame.
    task automatic send_frame(input logic g, input int n_pre, input int n, input int er_at, input logic odd);
        speed_1g_i = g;
        for (int i = 0; i < n_pre; i++) send_byte(g, 8'h55, 1'b0);
        send_byte(g, 8'hD5, 1'b0);
        speed_1g_i = ~g;
        for (int i = 0; i < n; i++) send_byte(g, 8'(i), i == er_at);
        if (odd) cyc(1'b1, 1'b1, 4'hA, 4'h0);
        speed_1g_i = g;
        fall_cyc = cyc_cnt;
        for (int i = 0; i < 4; i++) idle();
    endtask

    task automatic verify(input string tag, input int exp_n, input logic exp_user,
                          input int exp_ok, input int exp_err, input int exp_perr, input logic space);
        int bad   = 0;
        int nlast = 0;
        int viol  = 0;
        int sz;
        sz = beats.size();
        check({tag, "/beats"}, sz, exp_n);
        for (int i = 0; i < sz; i++) begin
            if (beats[i].d !== 8'(i)) bad++;
            if (beats[i].last) nlast++;
            if (space && i > 0 && i < sz - 1 && (beats[i].cyc - beats[i-1].cyc) < 2) viol++;
        end
        check({tag, "/data_errs"}, bad, 0);
        check({tag, "/tlast_count"}, nlast, (exp_n > 0) ? 1 : 0);
        check({tag, "/frame_ok"}, n_ok, exp_ok);
        check({tag, "/frame_err"}, n_err, exp_err);
        check({tag, "/preamble_err"}, n_perr, exp_perr);
        if (sz > 0) begin
            check({tag, "/last_flag"}, beats[sz-1].last, 1);
            check({tag, "/tuser"}, beats[sz-1].user, exp_user);
            check({tag, "/status_with_tlast"}, beats[sz-1].st, 1);
            check({tag, "/tlast_latency"}, beats[sz-1].cyc, fall_cyc + 1);
        end
        if (space) check({tag, "/beat_spacing"}, viol, 0);
    endtask

    initial begin
        reset_n_i  = 1'b1;
        speed_1g_i = 1'b1;
        rxd_q1_i   = 4'h0;
        rxd_q2_i   = 4'h0;
        rxctl_q1_i = 1'b0;
        rxctl_q2_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        check("reset/outputs", {m_tdata_o, m_tvalid_o, m_tlast_o, m_tuser_o,
                                frame_ok_o, frame_err_o, preamble_err_o}, 0);
        repeat (3) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        repeat (3) idle();
        check("idle/outputs", {m_tdata_o, m_tvalid_o, m_tlast_o, m_tuser_o,
                               frame_ok_o, frame_err_o, preamble_err_o}, 0);

        clear();
        send_frame(1'b1, 7, 64, -1, 1'b0);
        verify("g1_good", 64, 1'b0, 1, 0, 0, 1'b0);

        clear();
        send_frame(1'b0, 7, 64, -1, 1'b0);
        verify("fe_good", 64, 1'b0, 1, 0, 0, 1'b1);

        clear();
        send_frame(1'b1, 7, 64, 20, 1'b0);
        verify("g1_rx_er", 64, 1'b1, 0, 1, 0, 1'b0);

        clear();
        speed_1g_i = 1'b1;
        send_byte(1'b1, 8'h55, 1'b0);
        send_byte(1'b1, 8'h55, 1'b0);
        send_byte(1'b1, 8'h57, 1'b0);
        send_byte(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(1'b1, 8'(i), 1'b0);
        fall_cyc = cyc_cnt;
        repeat (4) idle();
        verify("bad_preamble", 0, 1'b0, 0, 0, 1, 1'b0);

        clear();
        send_frame(1'b1, 7, 4, -1, 1'b0);
        verify("after_bad_pre", 4, 1'b0, 1, 0, 0, 1'b0);

        clear();
        send_frame(1'b1, 15, 4, -1, 1'b0);
        verify("pre_15", 4, 1'b0, 1, 0, 0, 1'b0);

        clear();
        send_frame(1'b1, 16, 4, -1, 1'b0);
        verify("pre_16", 0, 1'b0, 0, 0, 1, 1'b0);

        clear();
        send_frame(1'b0, 7, 5, -1, 1'b1);
        verify("fe_odd_nibble", 5, 1'b1, 0, 1, 0, 1'b1);

        clear();
        send_frame(1'b1, 7, 0, -1, 1'b0);
        verify("sfd_only", 0, 1'b0, 0, 1, 0, 1'b0);

        clear();
        send_frame(1'b1, 7, 1522, -1, 1'b0);
        verify("len_1522", 1522, 1'b0, 1, 0, 0, 1'b0);

        clear();
        send_frame(1'b1, 7, 1600, -1, 1'b0);
        verify("len_1600", 1600, 1'b1, 0, 1, 0, 1'b0);

        // Reset while byte 30 is on the wire: bytes 0..28 have been emitted.
        clear();
        speed_1g_i = 1'b1;
        for (int i = 0; i < 7; i++) send_byte(1'b1, 8'h55, 1'b0);
        send_byte(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) send_byte(1'b1, 8'(i), 1'b0);
        rxd_q1_i = 4'hE;
        rxd_q2_i = 4'h1;
        @(negedge clk_i);
        #1;
        check("rst_mid/valid_before", m_tvalid_o, 1);
        reset_n_i = 1'b0;
        #1;
        check("rst_mid/outputs", {m_tdata_o, m_tvalid_o, m_tlast_o, m_tuser_o,
                                  frame_ok_o, frame_err_o, preamble_err_o}, 0);
        rxctl_q1_i = 1'b0;
        rxctl_q2_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        repeat (3) idle();
        begin
            int bad   = 0;
            int nlast = 0;
            foreach (beats[i]) begin
                if (beats[i].d !== 8'(i)) bad++;
                if (beats[i].last) nlast++;
            end
            check("rst_mid/beats", beats.size(), 29);
            check("rst_mid/data_errs", bad, 0);
            check("rst_mid/tlast_count", nlast, 0);
            check("rst_mid/status_pulses", n_ok + n_err + n_perr, 0);
        end

        clear();
        send_frame(1'b1, 7, 16, -1, 1'b0);
        verify("after_reset", 16, 1'b0, 1, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_frame_ctrl.md
Name: rgmii_rx_frame_ctrl

Overview:
- Receive-side sequencer behind the per-bit source-synchronous DDR input capture on the RGMII RX pins.
- Takes the captured rising-edge/falling-edge data and control halves, builds bytes (1G: one byte per cycle; 10/100: two nibbles per byte), strips preamble/SFD and emits a framed byte stream with last/error marking and per-frame status pulses.
- Runs in the RX clock domain; an async FIFO downstream does the clock crossing.
- No backpressure: Ethernet cannot stall.

Parameters:
- max_len_p, 1522, maximum legal frame length in bytes (post-SFD, FCS included); longer frames are flagged bad.
- preamble_max_p, 15, maximum 0x55 bytes accepted before SFD; more bytes than this means the preamble is bad.

Ports:
- clk_i  in  1  RX clock (same clock that drives the DDR capture).
- reset_n_i  in  1  asynchronous, active-low reset.
- speed_1g_i  in  1  1 = gigabit DDR byte mode, 0 = 10/100 nibble mode.
- rxd_q1_i  in  4  RXD captured on the rising edge (low nibble).
- rxd_q2_i  in  4  RXD captured on the falling edge (high nibble, 1G only).
- rxctl_q1_i  in  1  RX_CTL on the rising edge (RX_DV).
- rxctl_q2_i  in  1  RX_CTL on the falling edge (RX_DV xor RX_ER).
- m_tdata_o  out  8  frame byte.
- m_tvalid_o  out  1  byte valid.
- m_tlast_o  out  1  last byte of the frame.
- m_tuser_o  out  1  frame bad; only meaningful when m_tlast_o=1.
- frame_ok_o  out  1  one-cycle pulse: good frame ended.
- frame_err_o  out  1  one-cycle pulse: bad frame ended.
- preamble_err_o  out  1  one-cycle pulse: preamble/SFD violation.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, nibble phase 0, counters 0. Reset is asynchronous.
- Line decode: dv = rxctl_q1_i; er = rxctl_q1_i ^ rxctl_q2_i.
- speed_1g_i is latched only in IDLE, at frame start. A change mid-frame has no effect until the next IDLE.
- Byte build, 1G: byte = {rxd_q2_i, rxd_q1_i}, one per cycle while dv=1.
- Byte build, 10/100: low nibble is taken when phase=0, high nibble when phase=1. The byte completes on phase=1. Phase toggles each dv=1 cycle and clears when dv=0.
- FSM IDLE:
  - dv=1 with completed byte 0x55 -> PREAMBLE, preamble count = 1.
  - dv=1 with any other completed byte -> DROP, preamble_err pulse.
  - er while dv=0 is ignored.
- FSM PREAMBLE:
  - Byte 0x55 increments the count; count > preamble_max_p -> DROP, preamble_err pulse.
  - Byte 0xD5 -> DATA, clears length count and error flag.
  - Any other byte -> DROP, preamble_err pulse.
  - dv=0 -> IDLE, silent (no output, no pulse).
- FSM DATA:
  - Each completed byte is written into a one-byte hold register.
  - If the hold register was already full, its previous content is emitted (tvalid=1, tlast=0).
  - er=1 on any DATA cycle sets the error flag.
  - The length counter is 16 bits and saturates; length > max_len_p sets the oversize flag. Bytes are still forwarded.
- DATA, dv falls:
  - If the hold register is full: emit the held byte with tlast=1 and tuser = err | oversize | (10/100 and phase=1, i.e. odd nibble). Pulse frame_ok or frame_err in the same cycle as tlast. Go to IDLE.
  - If the hold register is empty (SFD then immediate dv drop): no beat, frame_err pulse, go to IDLE.
- FSM DROP: wait for dv=0, then -> IDLE. No output in this state.
- Latency: byte k completed at cycle t_k appears registered on m_tdata_o at cycle t_{k+1}+1. The last byte appears at (first dv=0 cycle)+1.
- Outputs are registered. tvalid is never asserted in two consecutive cycles in 10/100 mode.
- Back-to-back frames: from the tlast-emit cycle IDLE is already active, so a frame starting with one dv=0 gap is accepted.
- Reset mid-frame: the output stream is truncated with no tlast and no status pulse. Downstream treats reset as a frame abort.

Decomposition:
- Package rgmii_rx_pkg: FSM state enum {IDLE, PREAMBLE, DATA, DROP}, constants preamble byte 0x55 and SFD 0xD5, length counter width 16.
- Sub-module rgmii_rx_nibble_pack:
  - Inputs: dv, speed latch, q1/q2.
  - Outputs: byte, byte_valid, phase.
  - Owns phase and low-nibble registers.
- The FSM, hold register, counters and status logic stay in the top module.

Test Plan:
- 1G, dv=1 with 7x0x55, 0xD5, bytes 0x00..0x3F, then dv=0 -> 64 beats 0x00..0x3F, tlast on 0x3F, tuser=0, one frame_ok pulse in the same cycle.
- 10/100, same frame sent as nibbles (low first) -> identical 64-beat stream, beats spaced at least 2 cycles apart, frame_ok.
- 1G, rxctl_q2=0 for one cycle at byte 20 (er=1) -> all 64 beats delivered, tuser=1 at tlast, frame_err pulse, no frame_ok.
- 1G, preamble 0x55,0x55,0x57 -> no beats, one preamble_err pulse, no output until dv falls and the next good frame starts.
- 10/100, odd nibble count (5 data bytes + 1 nibble) -> 5 beats, tuser=1 at tlast, frame_err. Separately, 1G 1600-byte frame with max_len_p=1522 -> 1600 beats, tuser=1 at tlast.
- Assert reset_n_i low at byte 30 of a 1G frame -> outputs 0 that same cycle; after release, a following good frame is received intact with frame_ok.
